// File: rtl/mul_seq.sv
// Multi-cycle multiply / multiply-accumulate unit with signed or unsigned operands.
// It retires BPC multiplier bits per cycle, finishes early and uses a start/busy/done handshake.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int BPC   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] B_In,
  input  logic [WIDTH-1:0] C,
  input  logic             U,
  input  logic             ACC,
  input  logic             LONG,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             HI_LO,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] B_Out
);

  localparam int DW    = 2 * WIDTH;
  localparam int ITERS = DW / BPC;
  localparam int IW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] mcand, mplier, prod, result;
  logic [IW-1:0] iter;

  logic [DW-1:0] ext_b, ext_c, acc_ext;
  logic [DW-1:0] partial, prod_sum, mplier_shift;
  logic [IW-1:0] iter_inc;
  logic          finish;

  always_comb begin
    ext_b   = U ? {{WIDTH{B_In[WIDTH-1]}}, B_In} : {{WIDTH{1'b0}}, B_In};
    ext_c   = U ? {{WIDTH{C[WIDTH-1]}}, C} : {{WIDTH{1'b0}}, C};
    acc_ext = LONG ? {acc_hi, acc_lo} : {{WIDTH{1'b0}}, acc_lo};
  end

  // One digit step: add the shifted multiplicand times the low BPC multiplier bits.
  always_comb begin
    partial      = mcand * DW'(mplier[BPC-1:0]);
    prod_sum     = prod + partial;
    mplier_shift = mplier >> BPC;
    iter_inc     = iter + IW'(1);
    finish       = (mplier_shift == '0) || (iter_inc == IW'(ITERS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      result <= '0;
      iter   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= ext_b;
            mplier <= ext_c;
            prod   <= ACC ? acc_ext : '0;
            iter   <= '0;
          end
        end
        RUN: begin
          mcand  <= mcand << BPC;
          mplier <= mplier_shift;
          prod   <= prod_sum;
          iter   <= iter_inc;
          // The result register only changes on the last iteration.
          if (finish) result <= prod_sum;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign B_Out = HI_LO ? result[DW-1:WIDTH] : result[WIDTH-1:0];

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases, randomized operations
// checked against an arithmetic reference model, handshake and reset scenarios.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] B_In = '0;
  logic [31:0] C = '0;
  logic        U = 1'b0;
  logic        ACC = 1'b0;
  logic        LONG = 1'b0;
  logic [31:0] acc_hi = '0;
  logic [31:0] acc_lo = '0;
  logic        HI_LO = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] B_Out;

  int checks = 0;
  int failures = 0;

  mul_seq #(.WIDTH(32), .BPC(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .B_In(B_In),
    .C(C),
    .U(U),
    .ACC(ACC),
    .LONG(LONG),
    .acc_hi(acc_hi),
    .acc_lo(acc_lo),
    .HI_LO(HI_LO),
    .busy(busy),
    .done(done),
    .B_Out(B_Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        u;
    logic        acc_en;
    logic        long_en;
    logic [31:0] ahi;
    logic [31:0] alo;
    logic [63:0] expected;
    int          cycles;
  } vec_t;

  // Reference: product of the extended operands plus accumulator, modulo 2^64.
  function automatic logic [63:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic u, input logic acc_en,
                                               input logic long_en, input logic [31:0] ahi,
                                               input logic [31:0] alo);
    logic [63:0] ea, eb, acc;
    ea  = u ? {{32{a[31]}}, a} : {32'h0, a};
    eb  = u ? {{32{b[31]}}, b} : {32'h0, b};
    acc = acc_en ? (long_en ? {ahi, alo} : {32'h0, alo}) : 64'h0;
    return ea * eb + acc;
  endfunction

  // Reference: k = ceil(significant extended multiplier bits / 8), at least 1.
  function automatic int model_k(input logic [31:0] b, input logic u);
    logic [63:0] eb;
    int bits;
    eb = u ? {{32{b[31]}}, b} : {32'h0, b};
    bits = 0;
    for (int i = 0; i < 64; i++) if (eb[i]) bits = i + 1;
    if (bits == 0) return 1;
    return (bits + 7) / 8;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                        input logic acc_en, input logic long_en, input logic [31:0] ahi,
                        input logic [31:0] alo, output int cycles);
    wait_idle();
    B_In = a; C = b; U = u; ACC = acc_en; LONG = long_en; acc_hi = ahi; acc_lo = alo;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs after capture; the unit must ignore them.
    B_In = $urandom; C = $urandom; U = 1'($urandom); ACC = 1'($urandom);
    LONG = 1'($urandom); acc_hi = $urandom; acc_lo = $urandom;
    cycles = 1;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic read_result(output logic [63:0] r);
    HI_LO = 1'b0;
    #1;
    r[31:0] = B_Out;
    HI_LO = 1'b1;
    #1;
    r[63:32] = B_Out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    HI_LO = 1'b0;
    #1;
    checks++;
    if (B_Out !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_bout_lo: got %h expected 0", B_Out);
    end
    HI_LO = 1'b1;
    #1;
    checks++;
    if (B_Out !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_bout_hi: got %h expected 0", B_Out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t vecs[7];
    int cycles;
    logic [63:0] r;
    vecs[0] = '{32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'd15, 2};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                64'hFFFFFFFE_00000001, 5};
    vecs[2] = '{32'd2, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                64'hFFFFFFFF_FFFFFFFE, 9};
    vecs[3] = '{32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                64'h00000001_FFFFFFFE, 5};
    vecs[4] = '{32'd2, 32'd3, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFF,
                64'h00000002_00000005, 2};
    vecs[5] = '{32'd2, 32'd3, 1'b0, 1'b1, 1'b0, 32'h00000001, 32'hFFFFFFFF,
                64'h00000001_00000005, 2};
    vecs[6] = '{32'd123, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000DEAD, 32'h0000BEEF,
                64'h0000DEAD_0000BEEF, 2};
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].u, vecs[i].acc_en, vecs[i].long_en,
             vecs[i].ahi, vecs[i].alo, cycles);
      checks++;
      if (cycles !== vecs[i].cycles) begin
        failures++;
        $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, cycles, vecs[i].cycles);
      end
      read_result(r);
      checks++;
      if (r[31:0] !== vecs[i].expected[31:0]) begin
        failures++;
        $display("[TB] FAIL directed%0d_lo: got %h expected %h", i, r[31:0], vecs[i].expected[31:0]);
      end
      checks++;
      if (r[63:32] !== vecs[i].expected[63:32]) begin
        failures++;
        $display("[TB] FAIL directed%0d_hi: got %h expected %h", i, r[63:32], vecs[i].expected[63:32]);
      end
    end
  endtask

  task automatic test_random();
    int cycles, k;
    logic [31:0] a, b, ahi, alo;
    logic u, acc_en, long_en;
    logic [63:0] r, expected;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 3) b = 32'h0;
      u = 1'($urandom); acc_en = 1'($urandom); long_en = 1'($urandom);
      ahi = $urandom; alo = $urandom;
      expected = model_result(a, b, u, acc_en, long_en, ahi, alo);
      k = model_k(b, u);
      run_op(a, b, u, acc_en, long_en, ahi, alo, cycles);
      checks++;
      if (cycles !== k + 1) begin
        failures++;
        $display("[TB] FAIL random%0d_latency: got %0d expected %0d (C=%h U=%b)", i, cycles, k + 1, b, u);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("[TB] FAIL random%0d_busy_in_done: got %b expected 1", i, busy);
      end
      read_result(r);
      checks++;
      if (r !== expected) begin
        failures++;
        $display("[TB] FAIL random%0d_result: got %h expected %h", i, r, expected);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    logic [63:0] r;
    wait_idle();
    B_In = 32'd7; C = 32'h12345; U = 1'b0; ACC = 1'b0; LONG = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    cycles = 1;
    // Hold start high with fresh operands while busy; all of it must be ignored.
    while (!done && cycles < 40) begin
      B_In = $urandom; C = $urandom; U = 1'($urandom); ACC = 1'($urandom);
      @(posedge clk);
      #1;
      cycles++;
    end
    checks++;
    if (cycles !== 4) begin
      failures++; $display("[TB] FAIL b2b_latency: got %0d expected 4", cycles);
    end
    read_result(r);
    checks++;
    if (r !== 64'd7 * 64'h12345) begin
      failures++; $display("[TB] FAIL b2b_first_result: got %h expected %h", r, 64'd7 * 64'h12345);
    end
    B_In = 32'd9; C = 32'd11; U = 1'b0; ACC = 1'b0; LONG = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("[TB] FAIL b2b_start_in_done_ignored: got busy,done=%b expected 00", {busy, done});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_accept_in_idle: got busy=%b expected 1", busy);
    end
    cycles = 1;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checks++;
    if (cycles !== 2) begin
      failures++; $display("[TB] FAIL b2b_second_latency: got %0d expected 2", cycles);
    end
    read_result(r);
    checks++;
    if (r !== 64'd99) begin
      failures++; $display("[TB] FAIL b2b_second_result: got %h expected %h", r, 64'd99);
    end
  endtask

  task automatic test_reset_mid_run();
    int cycles;
    logic [63:0] r;
    wait_idle();
    B_In = 32'd5; C = 32'hFFFFFFFF; U = 1'b1; ACC = 1'b0; LONG = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL midrun_busy_before_reset: got %b expected 1", busy);
    end
    #2;
    rst_n = 1'b0;
    HI_LO = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("[TB] FAIL midrun_reset_flags: got busy,done=%b expected 00", {busy, done});
    end
    checks++;
    if (B_Out !== 32'h0) begin
      failures++; $display("[TB] FAIL midrun_reset_bout: got %h expected 0", B_Out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cycles);
    checks++;
    if (cycles !== 2) begin
      failures++; $display("[TB] FAIL midrun_clean_latency: got %0d expected 2", cycles);
    end
    read_result(r);
    checks++;
    if (r !== 64'd15) begin
      failures++; $display("[TB] FAIL midrun_clean_result: got %h expected %h", r, 64'd15);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
